// File: rtl/output_requant.sv
// Three-stage requantizer: per-channel scale multiply, rounding right shift
// plus zero point, then clamp to the signed output range with optional ReLU.
module output_requant #(
  parameter int NUM_CH  = 4,
  parameter int IN_W    = 20,
  parameter int OUT_W   = 8,
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_CH*IN_W-1:0]    in_data,
  input  logic [NUM_CH*SCALE_W-1:0] cfg_scale,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic [OUT_W-1:0]          cfg_zp,
  input  logic                      cfg_relu,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH*OUT_W-1:0]   out_data,
  output logic [NUM_CH-1:0]         out_sat,
  output logic [15:0]               sat_count,
  input  logic                      cnt_clr,
  output logic                      busy
);

  localparam int PW  = IN_W + SCALE_W + 1;
  // Two guard bits absorb the rounding constant and the zero-point add.
  localparam int RW  = PW + 2;
  localparam int PCW = $clog2(NUM_CH + 1) + 1;
  localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = -SAT_MAX - 1;

  logic v1, v2, v3;
  logic en;
  logic signed [PW-1:0] p1    [NUM_CH];
  logic signed [PW-1:0] p_nxt [NUM_CH];
  logic signed [RW-1:0] r2    [NUM_CH];
  logic signed [RW-1:0] r_nxt [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] o_nxt;
  logic [NUM_CH-1:0]       s_nxt;
  logic [PCW-1:0]          pop;
  logic [16:0]             cnt_sum;

  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;
  assign busy      = v1 || v2 || v3;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      p_nxt[i] = $signed({{(PW-IN_W){in_data[i*IN_W+IN_W-1]}}, in_data[i*IN_W +: IN_W]})
               * $signed({{(PW-SCALE_W){1'b0}}, cfg_scale[i*SCALE_W +: SCALE_W]});
    end
  end

  logic signed [RW-1:0] zp_ext;
  logic signed [RW-1:0] rnd;
  assign zp_ext = $signed({{(RW-OUT_W){cfg_zp[OUT_W-1]}}, cfg_zp});
  assign rnd    = (cfg_shift == '0) ? '0
                : ({{(RW-1){1'b0}}, 1'b1} << (cfg_shift - 1'b1));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      r_nxt[i] = (($signed({{2{p1[i][PW-1]}}, p1[i]}) + rnd) >>> cfg_shift) + zp_ext;
    end
  end

  // ReLU clamp is checked first so it never reports as saturation.
  always_comb begin
    o_nxt = '0;
    s_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_relu && (r2[i] < zp_ext)) begin
        o_nxt[i*OUT_W +: OUT_W] = cfg_zp;
      end else if (r2[i] > SAT_MAX) begin
        o_nxt[i*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        s_nxt[i] = 1'b1;
      end else if (r2[i] < SAT_MIN) begin
        o_nxt[i*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
        s_nxt[i] = 1'b1;
      end else begin
        o_nxt[i*OUT_W +: OUT_W] = r2[i][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      out_data <= '0;
      out_sat  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        p1[i] <= '0;
        r2[i] <= '0;
      end
    end else if (en) begin
      v1       <= in_valid;
      v2       <= v1;
      v3       <= v2;
      out_data <= o_nxt;
      out_sat  <= s_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        p1[i] <= p_nxt[i];
        r2[i] <= r_nxt[i];
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + {{(PCW-1){1'b0}}, out_sat[i]};
    end
  end

  assign cnt_sum = {1'b0, sat_count} + {{(17-PCW){1'b0}}, pop};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sat_count <= '0;
    end else if (cnt_clr) begin
      sat_count <= '0;
    end else if (v3 && out_ready) begin
      sat_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

endmodule

// File: tb/tb_output_requant.sv
// Directed bench for output_requant with default parameters (4 ch, 20b in, 8b out).
module tb_output_requant;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] in_data;
  logic [63:0] cfg_scale;
  logic [4:0]  cfg_shift;
  logic [7:0]  cfg_zp;
  logic        cfg_relu;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_sat;
  logic [15:0] sat_count;
  logic        cnt_clr;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  output_requant dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
    .cfg_zp(cfg_zp), .cfg_relu(cfg_relu), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_count(sat_count), .cnt_clr(cnt_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] pack_in(input int a0, input int a1, input int a2, input int a3);
    logic [31:0] b0, b1, b2, b3;
    b0 = a0; b1 = a1; b2 = a2; b3 = a3;
    return {b3[19:0], b2[19:0], b1[19:0], b0[19:0]};
  endfunction

  function automatic logic [31:0] pack_out(input int a0, input int a1, input int a2, input int a3);
    logic [31:0] b0, b1, b2, b3;
    b0 = a0; b1 = a1; b2 = a2; b3 = a3;
    return {b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
  endfunction

  task automatic set_cfg(input int scale, input int shift, input int zp, input logic relu);
    logic [31:0] s, z;
    s = scale; z = zp;
    cfg_scale = {4{s[15:0]}};
    cfg_shift = shift[4:0];
    cfg_zp    = z[7:0];
    cfg_relu  = relu;
  endtask

  // Sends one beat and returns at the negedge where out_valid first rises.
  task automatic send_beat(input logic [79:0] d, output int lat);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    #12;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: out_valid=%b busy=%b, want 0 0", out_valid, busy);
    end
    n_tests++;
    if (out_data !== 32'd0 || out_sat !== 4'd0 || sat_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_data: out_data=%h out_sat=%b sat_count=%0d, want 0", out_data, out_sat, sat_count);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    set_cfg(256, 8, 0, 1'b0);
    send_beat(pack_in(100, 100, 100, 100), lat);
    n_tests++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 3", lat);
    end
    n_tests++;
    if (out_data !== pack_out(100, 100, 100, 100) || out_sat !== 4'b0000) begin
      n_fail++; $display("FAIL basic_data: out_data=%h sat=%b want %h 0000", out_data, out_sat, pack_out(100, 100, 100, 100));
    end
  endtask

  task automatic test_rounding;
    int lat;
    set_cfg(1, 1, 0, 1'b0);
    send_beat(pack_in(3, -3, 5, -5), lat);
    n_tests++;
    if (lat !== 3 || out_data !== pack_out(2, -1, 3, -2) || out_sat !== 4'b0000) begin
      n_fail++; $display("FAIL rounding: lat=%0d out_data=%h sat=%b want 3 %h 0000", lat, out_data, out_sat, pack_out(2, -1, 3, -2));
    end
  endtask

  task automatic test_saturation;
    int lat;
    set_cfg(1, 0, 0, 1'b0);
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    send_beat(pack_in(1000, -1000, 5, 0), lat);
    n_tests++;
    if (out_data !== pack_out(127, -128, 5, 0) || out_sat !== 4'b0011) begin
      n_fail++; $display("FAIL sat_data: out_data=%h sat=%b want %h 0011", out_data, out_sat, pack_out(127, -128, 5, 0));
    end
    @(negedge clk);
    n_tests++;
    if (sat_count !== 16'd2) begin
      n_fail++; $display("FAIL sat_count_inc: got %0d want 2", sat_count);
    end
    send_beat(pack_in(1000, -1000, 5, 0), lat);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    n_tests++;
    if (sat_count !== 16'd0) begin
      n_fail++; $display("FAIL sat_count_clr_priority: got %0d want 0", sat_count);
    end
  endtask

  task automatic test_relu;
    int lat;
    set_cfg(1, 0, 10, 1'b1);
    send_beat(pack_in(-50, 0, 20, 200), lat);
    n_tests++;
    if (out_data !== pack_out(10, 10, 30, 127) || out_sat !== 4'b1000) begin
      n_fail++; $display("FAIL relu: out_data=%h sat=%b want %h 1000", out_data, out_sat, pack_out(10, 10, 30, 127));
    end
    @(negedge clk);
    n_tests++;
    if (sat_count !== 16'd1) begin
      n_fail++; $display("FAIL relu_count: got %0d want 1", sat_count);
    end
  endtask

  task automatic test_count_limit;
    set_cfg(1, 0, 0, 1'b0);
    @(negedge clk);
    in_data  = pack_in(1000, 1000, -1000, -1000);
    in_valid = 1'b1;
    repeat (16400) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (sat_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL count_limit: got %h want ffff", sat_count);
    end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    int sent, recv, t, extra;
    logic acc, hs, holding, stall_seen;
    logic [31:0] held;
    sent = 0; recv = 0; t = 0; holding = 1'b0; stall_seen = 1'b0; held = '0;
    set_cfg(1, 0, 0, 1'b0);
    while (recv < 8 && t < 60) begin
      @(negedge clk);
      out_ready = !(t >= 4 && t < 9);
      in_valid  = (sent < 8);
      in_data   = pack_in(sent*10, sent*10+1, sent*10+2, sent*10+3);
      #1;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (out_valid && !out_ready) begin
        stall_seen = 1'b1;
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_in_ready: got %b want 0 at t=%0d", in_ready, t);
        end
        if (!holding) begin
          held = out_data;
          holding = 1'b1;
        end else begin
          n_tests++;
          if (out_data !== held) begin
            n_fail++; $display("FAIL bp_stable: got %h want %h at t=%0d", out_data, held, t);
          end
        end
      end
      if (hs) begin
        n_tests++;
        if (out_data !== pack_out(recv*10, recv*10+1, recv*10+2, recv*10+3)) begin
          n_fail++; $display("FAIL bp_order: beat %0d got %h want %h", recv, out_data,
                             pack_out(recv*10, recv*10+1, recv*10+2, recv*10+3));
        end
        recv++;
      end
      @(posedge clk);
      if (acc) sent++;
      t++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_tests++;
    if (recv !== 8 || sent !== 8 || stall_seen !== 1'b1) begin
      n_fail++; $display("FAIL bp_count: sent=%0d recv=%0d stall=%b want 8 8 1", sent, recv, stall_seen);
    end
    extra = 0;
    repeat (6) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL bp_duplicate: got %0d extra beats want 0", extra);
    end
  endtask

  task automatic test_reset_midstream;
    int lat, stale;
    set_cfg(1, 0, 0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pack_in(b+1, b+2, b+3, b+4);
      @(posedge clk);
    end
    #2;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy: got %b want 1", busy);
    end
    nrst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'd0 || out_sat !== 4'd0 || sat_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset_clear: valid=%b busy=%b data=%h sat=%b cnt=%0d want all 0",
                         out_valid, busy, out_data, out_sat, sat_count);
    end
    @(negedge clk);
    nrst = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_tests++;
    if (stale !== 0) begin
      n_fail++; $display("FAIL mid_stale: got %0d stale beats want 0", stale);
    end
    send_beat(pack_in(7, 8, 9, 10), lat);
    n_tests++;
    if (lat !== 3 || out_data !== pack_out(7, 8, 9, 10)) begin
      n_fail++; $display("FAIL mid_recover: lat=%0d data=%h want 3 %h", lat, out_data, pack_out(7, 8, 9, 10));
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    set_cfg(1, 0, 0, 1'b0);
    test_reset;
    test_basic;
    test_rounding;
    test_saturation;
    test_relu;
    test_count_limit;
    test_back_to_back;
    test_reset_midstream;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
